// File: rtl/pq_mont_vec_seq.sv
`timescale 1ns/1ps
// Lane-serial Montgomery multiplier for packed vectors: one shared combinational
// REDC datapath handles one lane per cycle under an IDLE/BUSY/DONE sequencer.

module pq_mont_mul #(
   parameter int DATA_WIDTH = 32,
   parameter int LOG_R      = 32
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [DATA_WIDTH-1:0] q_i,
   input  logic [LOG_R-1:0]      q_dash_i,
   output logic [DATA_WIDTH-1:0] res_o
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int SW = PW + LOG_R + 1;

   logic [PW-1:0]    w_prod;
   logic [LOG_R-1:0] w_m;
   logic [SW-1:0]    w_sum;
   logic [SW-1:0]    w_t;

   // t < 2q for in-range operands, so a single subtract finishes the reduction
   function automatic logic [DATA_WIDTH-1:0] cond_sub(input logic [SW-1:0] t,
                                                      input logic [DATA_WIDTH-1:0] q);
      logic [SW-1:0] d;
      d = (t >= SW'(q)) ? (t - SW'(q)) : t;
      return d[DATA_WIDTH-1:0];
   endfunction

   assign w_prod = PW'(a_i) * PW'(b_i);
   assign w_m    = w_prod[LOG_R-1:0] * q_dash_i;
   assign w_sum  = SW'(w_prod) + SW'(w_m) * SW'(q_i);
   assign w_t    = w_sum >> LOG_R;
   assign res_o  = cond_sub(w_t, q_i);
endmodule

module pq_mont_vec_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int LOG_R      = 32,
   parameter int NUM_LANES  = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] op0_i,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] op1_i,
   input  logic                            bcast_i,
   input  logic [DATA_WIDTH-1:0]           q_i,
   input  logic [LOG_R-1:0]                q_dash_i,
   input  logic                            clear_i,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [NUM_LANES*DATA_WIDTH-1:0] res_o,
   output logic                            busy_o
);
   localparam int VW = NUM_LANES * DATA_WIDTH;
   localparam int CW = $clog2(NUM_LANES);
   localparam logic [CW-1:0] LAST_LANE = CW'(NUM_LANES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_cnt;
   logic [VW-1:0]         r_op0;
   logic [VW-1:0]         r_op1;
   logic [DATA_WIDTH-1:0] r_q;
   logic [LOG_R-1:0]      r_q_dash;
   logic [VW-1:0]         r_res;
   logic [VW-1:0]         w_op1_exp;
   logic [DATA_WIDTH-1:0] w_lane_a;
   logic [DATA_WIDTH-1:0] w_lane_b;
   logic [DATA_WIDTH-1:0] w_lane_r;
   logic                  w_accept;

   assign w_op1_exp = bcast_i ? {NUM_LANES{op1_i[DATA_WIDTH-1:0]}} : op1_i;
   assign w_accept  = (r_state == S_IDLE) && in_valid_i && !clear_i;

   assign in_ready_o  = (r_state == S_IDLE) && !clear_i;
   assign out_valid_o = (r_state == S_DONE);
   assign busy_o      = (r_state != S_IDLE);
   assign res_o       = r_res;

   assign w_lane_a = r_op0[r_cnt*DATA_WIDTH +: DATA_WIDTH];
   assign w_lane_b = r_op1[r_cnt*DATA_WIDTH +: DATA_WIDTH];

   pq_mont_mul #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG_R      (LOG_R)
   ) u_mul (
      .a_i      (w_lane_a),
      .b_i      (w_lane_b),
      .q_i      (r_q),
      .q_dash_i (r_q_dash),
      .res_o    (w_lane_r)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_BUSY;
         S_BUSY:  if (r_cnt == LAST_LANE) w_next = S_DONE;
         S_DONE:  if (out_ready_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (clear_i) w_next = S_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_next;
         if (clear_i || w_accept) begin
            r_cnt <= '0;
            r_res <= '0;
         end else if (r_state == S_BUSY) begin
            r_res[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= w_lane_r;
            if (r_cnt != LAST_LANE) r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Operand capture happens only on the accept edge; later input changes are invisible
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_op0    <= op0_i;
         r_op1    <= w_op1_exp;
         r_q      <= q_i;
         r_q_dash <= q_dash_i;
      end
   end
endmodule
